// File: rtl/swervolf_keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row synchronisation, scan-level
// debounce and a single-entry valid/ready event register with sticky overflow.
module swervolf_keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_core,
    input  logic       rst_core,
    output logic [3:0] o_col,
    input  logic [3:0] i_row,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    input  logic       i_key_ready,
    output logic       o_key_down,
    output logic       o_overflow,
    input  logic       i_ovf_clr
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [11:0]   snap;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    logic          dwell_end, scan_done;
    logic [15:0]   scan_full;
    logic [4:0]    n_keys;
    logic [3:0]    key_idx;
    logic [3:0]    key_code;
    logic          single, none;
    logic [CW-1:0] cnt_inc;
    logic          emit;

    assign dwell_end = (div == DIV_LAST);
    assign scan_done = dwell_end && (col_idx == 2'd3);
    // Column 3 is merged live so the decision lands on the same edge as its sample.
    assign scan_full = {~row_sync, snap};

    always_comb begin
        n_keys  = '0;
        key_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (scan_full[i]) begin
                n_keys  = n_keys + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign single = (n_keys == 5'd1);
    assign none   = (n_keys == 5'd0);

    // Snapshot index is 4*col + row.
    always_comb begin
        case (key_idx)
            4'd0:  key_code = 4'h1;
            4'd1:  key_code = 4'h4;
            4'd2:  key_code = 4'h7;
            4'd3:  key_code = 4'h0;
            4'd4:  key_code = 4'h2;
            4'd5:  key_code = 4'h5;
            4'd6:  key_code = 4'h8;
            4'd7:  key_code = 4'hF;
            4'd8:  key_code = 4'h3;
            4'd9:  key_code = 4'h6;
            4'd10: key_code = 4'h9;
            4'd11: key_code = 4'hE;
            4'd12: key_code = 4'hA;
            4'd13: key_code = 4'hB;
            4'd14: key_code = 4'hC;
            default: key_code = 4'hD;
        endcase
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    assign emit = scan_done && single &&
                  ((state == IDLE && DEBOUNCE == 1) ||
                   (state == PRESS_CHK && key_code == cand && cnt_inc == CNT_MAX));

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            row_meta <= '1;
            row_sync <= '1;
            div      <= '0;
            col_idx  <= '0;
            o_col    <= 4'b1110;
            snap     <= '0;
        end else begin
            row_meta <= i_row;
            row_sync <= row_meta;
            if (dwell_end) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                o_col   <= {o_col[2:0], o_col[3]};
                case (col_idx)
                    2'd0:    snap[3:0]  <= ~row_sync;
                    2'd1:    snap[7:4]  <= ~row_sync;
                    2'd2:    snap[11:8] <= ~row_sync;
                    default: ;
                endcase
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= '0;
            o_key_down <= 1'b0;
        end else if (scan_done) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand <= key_code;
                        if (DEBOUNCE == 1) begin
                            state      <= HELD;
                            cnt        <= '0;
                            o_key_down <= 1'b1;
                        end else begin
                            state <= PRESS_CHK;
                            cnt   <= CW'(1);
                        end
                    end
                end
                PRESS_CHK: begin
                    if (single && key_code == cand) begin
                        if (cnt_inc == CNT_MAX) begin
                            state      <= HELD;
                            cnt        <= '0;
                            o_key_down <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                HELD: begin
                    if (none) begin
                        if (DEBOUNCE == 1) begin
                            state      <= IDLE;
                            o_key_down <= 1'b0;
                        end else begin
                            state <= REL_CHK;
                            cnt   <= CW'(1);
                        end
                    end
                end
                REL_CHK: begin
                    if (none) begin
                        if (cnt_inc == CNT_MAX) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            o_key_down <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        state <= HELD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    o_key_down <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_overflow  <= 1'b0;
        end else begin
            if (emit) begin
                if (!o_key_valid || i_key_ready) begin
                    o_key_valid <= 1'b1;
                    o_key_code  <= key_code;
                end
            end else if (i_key_ready) begin
                o_key_valid <= 1'b0;
            end
            if (emit && o_key_valid && !i_key_ready)
                o_overflow <= 1'b1;
            else if (i_ovf_clr)
                o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_swervolf_keypad_scan.sv
// Directed and randomized scan-by-scan checks of the keypad scanner against a
// key-set level model (SCAN_DIV=8, DEBOUNCE=2, 32-cycle scans).
module tb_swervolf_keypad_scan;

    localparam int SD  = 8;
    localparam int DEB = 2;

    logic       clk_core = 1'b0;
    logic       rst_core;
    logic [3:0] o_col;
    logic [3:0] i_row;
    logic       o_key_valid;
    logic [3:0] o_key_code;
    logic       i_key_ready;
    logic       o_key_down;
    logic       o_overflow;
    logic       i_ovf_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pressed keys, bit [4*row + col].
    logic [15:0] key_set;

    // Model state.
    bit         m_held;
    int         m_run, m_nrun;
    logic [3:0] m_cand;
    bit         m_valid, m_ovf;
    logic [3:0] m_code;

    swervolf_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk_core   (clk_core),
        .rst_core   (rst_core),
        .o_col      (o_col),
        .i_row      (i_row),
        .o_key_valid(o_key_valid),
        .o_key_code (o_key_code),
        .i_key_ready(i_key_ready),
        .o_key_down (o_key_down),
        .o_overflow (o_overflow),
        .i_ovf_clr  (i_ovf_clr)
    );

    always #5 clk_core = ~clk_core;

    // A row reads low when any pressed key in it sits on the driven column.
    always_comb begin
        i_row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_set[r*4 + c] && !o_col[c]) i_row[r] = 1'b0;
    end

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] v;
        v = '0;
        v[r*4 + c] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] code_of(input logic [15:0] k);
        logic [15:0] row_map [4];
        logic [15:0] rm;
        logic [3:0]  res;
        row_map = '{16'h123A, 16'h456B, 16'h789C, 16'h0FED};
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (k[r*4 + c]) begin
                    rm  = row_map[r];
                    res = 4'(rm >> (12 - 4*c));
                end
        return res;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_run = 0; m_nrun = 0; m_cand = '0;
        m_valid = 0; m_ovf = 0; m_code = '0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, {3'b0, o_key_valid}, {3'b0, m_valid});
        check({tag, ".code"},  o_key_code, m_code);
        check({tag, ".down"},  {3'b0, o_key_down}, {3'b0, m_held});
        check({tag, ".ovf"},   {3'b0, o_overflow}, {3'b0, m_ovf});
        check({tag, ".col"},   o_col, 4'b1110);
    endtask

    // One full scan with a fixed key set; called on a negedge at a scan boundary.
    task automatic run_scan(input logic [15:0] keys, input bit rdy, input bit clr, input string tag);
        int n;
        bit emit;
        logic [3:0] k;
        key_set     = keys;
        i_key_ready = rdy;
        for (int c = 1; c <= 4*SD; c++) begin
            @(negedge clk_core);
            i_ovf_clr = (clr && c == 5);
        end
        i_key_ready = 1'b0;
        i_ovf_clr   = 1'b0;

        if (rdy) m_valid = 0;
        if (clr) m_ovf = 0;
        n = $countones(keys);
        k = code_of(keys);
        emit = 0;
        if (!m_held) begin
            if (n == 1 && m_run > 0 && k == m_cand) m_run++;
            else if (n == 1 && m_run == 0) begin m_run = 1; m_cand = k; end
            else m_run = 0;
            if (m_run == DEB) begin emit = 1; m_held = 1; m_run = 0; end
        end else begin
            if (n == 0) m_nrun++; else m_nrun = 0;
            if (m_nrun == DEB) begin m_held = 0; m_nrun = 0; end
        end
        if (emit) begin
            if (!m_valid) begin m_valid = 1; m_code = k; end
            else m_ovf = 1;
        end
        check_model(tag);
    endtask

    initial begin
        logic [15:0] k5, k1, k2, kd, k0, k9, rk;
        int reps;
        k5 = kbit(1, 1); k1 = kbit(0, 0); k2 = kbit(0, 1);
        kd = kbit(3, 3); k0 = kbit(3, 0); k9 = kbit(2, 2);
        key_set = '0; i_key_ready = 0; i_ovf_clr = 0; rst_core = 1;
        model_reset();
        repeat (3) @(negedge clk_core);
        check("rst.col", o_col, 4'b1110);
        check("rst.valid", {3'b0, o_key_valid}, 4'h0);
        check("rst.code", o_key_code, 4'h0);
        check("rst.down", {3'b0, o_key_down}, 4'h0);
        check("rst.ovf", {3'b0, o_overflow}, 4'h0);
        rst_core = 0;

        // Free-running column rotation.
        for (int s = 1; s <= 4; s++) begin
            logic [3:0] one;
            repeat (SD) @(negedge clk_core);
            one = 4'b0001 << (s % 4);
            check("scan.col", o_col, ~one);
            check("scan.valid", {3'b0, o_key_valid}, 4'h0);
        end

        // Key 5 from before scan start: event after exactly two scans.
        run_scan(k5, 0, 0, "k5.s1");
        check("k5.s1.novalid", {3'b0, o_key_valid}, 4'h0);
        run_scan(k5, 0, 0, "k5.s2");
        check("k5.code", o_key_code, 4'h5);
        check("k5.valid", {3'b0, o_key_valid}, 4'h1);
        for (int i = 0; i < 5; i++) run_scan(k5, 0, 0, "k5.hold");
        check("k5.noovf", {3'b0, o_overflow}, 4'h0);

        // Short release then a different key: still held.
        run_scan('0, 0, 0, "rel1");
        for (int i = 0; i < 3; i++) run_scan(kd, 0, 0, "kd");
        check("kd.down", {3'b0, o_key_down}, 4'h1);
        check("kd.code", o_key_code, 4'h5);
        run_scan('0, 0, 0, "rel.a");
        run_scan('0, 0, 0, "rel.b");
        check("rel.down", {3'b0, o_key_down}, 4'h0);

        // New event while the old is still pending: dropped, overflow set.
        run_scan(k0, 0, 0, "k0.s1");
        run_scan(k0, 0, 0, "k0.s2");
        check("ovf.code", o_key_code, 4'h5);
        check("ovf.set", {3'b0, o_overflow}, 4'h1);
        run_scan(k0, 0, 1, "ovf.clr");
        check("ovf.clr", {3'b0, o_overflow}, 4'h0);
        run_scan(k0, 1, 0, "ack");
        check("ack.valid", {3'b0, o_key_valid}, 4'h0);

        // Two keys at once never register; single survivor does.
        run_scan('0, 0, 0, "rel0.a");
        run_scan('0, 0, 0, "rel0.b");
        for (int i = 0; i < 4; i++) run_scan(k1 | k2, 0, 0, "multi");
        check("multi.valid", {3'b0, o_key_valid}, 4'h0);
        check("multi.down", {3'b0, o_key_down}, 4'h0);
        run_scan(k1, 0, 0, "k1.s1");
        run_scan(k1, 0, 0, "k1.s2");
        check("k1.code", o_key_code, 4'h1);
        run_scan(k1, 1, 0, "k1.ack");

        // Bouncing key 9: never two matching scans in a row.
        run_scan('0, 0, 0, "rel1.a");
        run_scan('0, 0, 0, "rel1.b");
        for (int i = 0; i < 4; i++) begin
            run_scan(k9, 0, 0, "bounce.on");
            run_scan('0, 0, 0, "bounce.off");
        end
        check("bounce.valid", {3'b0, o_key_valid}, 4'h0);

        // Randomized key patterns, consumer readiness and overflow clears.
        for (int t = 0; t < 30; t++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 3) rk = '0;
            else if (sel < 8) rk = kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else rk = kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                    | kbit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            reps = int'($urandom_range(1, 3));
            for (int r = 0; r < reps; r++)
                run_scan(rk, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "rand");
        end

        // Leave a pending event, then reset mid-dwell.
        run_scan(k5, 0, 0, "pre.s1");
        run_scan(k5, 0, 0, "pre.s2");
        run_scan(k5, 0, 0, "pre.s3");
        repeat (13) @(negedge clk_core);
        rst_core = 1;
        @(negedge clk_core);
        rst_core = 0;
        key_set = '0;
        model_reset();
        check("mrst.col", o_col, 4'b1110);
        check("mrst.valid", {3'b0, o_key_valid}, 4'h0);
        check("mrst.down", {3'b0, o_key_down}, 4'h0);
        check("mrst.code", o_key_code, 4'h0);
        repeat (SD - 1) @(negedge clk_core);
        check("mrst.dwell", o_col, 4'b1110);
        @(negedge clk_core);
        check("mrst.next", o_col, 4'b1101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/swervolf_keypad_scan.md
# swervolf_keypad_scan

Scans a 4x4 matrix keypad (Pmod KYPD layout) by strobing columns and reading rows, and debounces and decodes a single pressed key into a 4-bit hex code. It is the input-side counterpart of the multiplexed seven-segment display driver in the SweRVolf Nexys A7 toplevel: that driver encodes nibbles onto scanned digits, while this block reads a scanned matrix back into nibbles. It sits in the `clk_core` domain and delivers key events to a GPIO or peripheral register through a valid/ready handshake.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: `clk_core` cycles each column is driven. Must be at least 4.
- `DEBOUNCE`, default 4: number of consecutive identical full scans required to accept a press or a release. Must be at least 1.

Ports:
- `clk_core` in 1: core clock. This block uses one clock only.
- `rst_core` in 1: reset, synchronous and active-high.
- `o_col` out 4: column strobes, active-low, exactly one bit low at a time.
- `i_row` in 4: row sense, active-low, asynchronous to `clk_core`.
- `o_key_valid` out 1: a key event is pending.
- `o_key_code` out 4: hex code of the pending event.
- `i_key_ready` in 1: consumer accepts the event.
- `o_key_down` out 1: a debounced key is currently held.
- `o_overflow` out 1: sticky flag; an event was dropped.
- `i_ovf_clr` in 1: clears `o_overflow`.

## Operation

- **Row synchronizer:** `i_row` passes through a 2-flop synchronizer before any use.
- **Column scan:**
  - A divider counts 0 to SCAN_DIV-1.
  - At the end of each dwell, `o_col` rotates left: 1110 → 1101 → 1011 → 0111 → 1110.
  - The synchronized rows are sampled on the dwell's last cycle (divider == SCAN_DIV-1) into a 16-bit snapshot at bits [4c+3:4c], where c is the column index.
  - The snapshot is complete when the column 3 sample is taken.
- **Key map (row r, col c):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: 0, F, E, D
- **Scan classification:**
  - Zero keys: NONE.
  - Exactly one key: SINGLE(k).
  - Two or more keys: MULTI, treated exactly as NONE for press detection and as "not released" in the HELD and REL_CHK states.
- **Debounce FSM** (evaluated once per completed scan; `cnt` is the debounce counter, `cand` the candidate code):
  - **IDLE:**
    - SINGLE(k) → PRESS_CHK with `cnt`=1, `cand`=k.
    - If DEBOUNCE==1, go directly to HELD and emit the event.
  - **PRESS_CHK:**
    - SINGLE(`cand`) → `cnt`++.
    - When `cnt` reaches DEBOUNCE → emit `cand`, go to HELD.
    - Any other scan → IDLE with `cnt`=0.
  - **HELD:**
    - NONE → REL_CHK with `cnt`=1.
    - If DEBOUNCE==1, go directly to IDLE.
    - Otherwise stay in HELD.
  - **REL_CHK:**
    - NONE → `cnt`++; when `cnt` reaches DEBOUNCE → IDLE.
    - Any key → HELD with `cnt`=0.
- **`o_key_down`:** 1 in HELD and REL_CHK.
- **Output register:**
  - On emit with `o_key_valid`=0, or with `o_key_valid`=1 and `i_key_ready`=1: load the code and set `o_key_valid`=1.
  - On emit with `o_key_valid`=1 and `i_key_ready`=0: the new event is dropped, the old code is kept, and `o_overflow` is set.
  - With no emit, `i_key_ready` clears `o_key_valid`.
- **`o_overflow`:** cleared by `i_ovf_clr`. If set and clear occur in the same cycle, set wins.
- **Counter widths:**
  - Divider: `$clog2(SCAN_DIV)` bits.
  - Debounce counter: `$clog2(DEBOUNCE+1)` bits, saturating (never wraps).

## Timing

- **Reset values:**
  - `o_col`=4'b1110.
  - `o_key_valid`=0, `o_key_code`=0, `o_key_down`=0, `o_overflow`=0.
  - Divider=0, FSM=IDLE, `cnt`=0, snapshot=0.
- **Reset mid-scan:** the partial snapshot and any pending event are discarded.
- **Scan period:** 4·SCAN_DIV cycles. A column changes on the cycle after divider==SCAN_DIV-1.
- **Settle time:** row settle plus synchronizer latency is SCAN_DIV-1 cycles, at least 3.
- **Event latency:** `o_key_valid` and `o_key_code` update 1 cycle after the column 3 sample of the accepting scan. `o_key_down` updates in that same cycle.
- **Handshake:**
  - Transfer occurs on a cycle where `o_key_valid`=1 and `i_key_ready`=1.
  - `o_key_code` is stable while `o_key_valid`=1.
- **Press latency:** a key stable from before a scan starts is reported after exactly DEBOUNCE full scans.

## Test plan

Common parameters: SCAN_DIV=8, DEBOUNCE=2. Scan period is 32 cycles.

1. Reset, then free-run → `o_col`=1110 at reset; 1101 at cycle 8; 1011 at 16; 0111 at 24; 1110 at 32. All other outputs stay 0.
2. Key 5 pressed (row1 low while col1 low) from before scan start, `i_key_ready`=0 → `o_key_valid`=1 with `o_key_code`=4'h5 one cycle after the second scan's col3 sample, and `o_key_down`=1. Holding the key for 5 more scans produces no further event; `o_overflow` stays 0.
3. Keys 1 and 2 held together for 4 scans → no event, `o_key_down`=0. Releasing 2 → event 4'h1 after 2 more scans.
4. In HELD, release key 5 for 1 scan, then press D for 3 scans → `o_key_down` stays 1 and no new event. Then release for 2 scans → `o_key_down`=0.
5. Event 4'h5 pending with `i_key_ready`=0; release for 2 scans, then press 0 for 2 scans → `o_key_code` stays 4'h5 and `o_overflow`=1. Pulse `i_ovf_clr` → `o_overflow`=0. Pulse `i_key_ready` → `o_key_valid`=0.
6. Key 9 toggles every 32 cycles, aligned to scans (bounce) → never two consecutive matching scans, so no event ever. Asserting `rst_core` mid-dwell → `o_col`=1110 and divider=0 on the next cycle.
